// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU slice: operation encoding and status flags.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_NOT = 3'd3,
        OP_ADD = 3'd4,
        OP_SUB = 3'd5,
        OP_SLT = 3'd6,
        OP_NOR = 3'd7
    } op_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: eight operations plus zero/neg/carry/ovf flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output flags_t           flags
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           lt;
    logic           add_ovf;
    logic           sub_ovf;

    assign sum  = {1'b0, a} + {1'b0, b};
    // Subtract as a + ~b + 1 so bit WIDTH is the no-borrow flag.
    assign diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign lt   = $signed(a) < $signed(b);

    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        y           = '0;
        flags.carry = 1'b0;
        flags.ovf   = 1'b0;
        unique case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_ADD: begin
                y           = sum[WIDTH-1:0];
                flags.carry = sum[WIDTH];
                flags.ovf   = add_ovf;
            end
            OP_SUB: begin
                y           = diff[WIDTH-1:0];
                flags.carry = diff[WIDTH];
                flags.ovf   = sub_ovf;
            end
            OP_SLT: y = {{(WIDTH-1){1'b0}}, lt};
            OP_NOR: y = ~(a | b);
        endcase
        flags.zero = (y == '0);
        flags.neg  = y[WIDTH-1];
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 captures operands, S2 registers result and flags.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf
);

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] core_y;
    flags_t           core_flags;
    flags_t           s2_flags;

    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_AND;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= op_e'(op);
                s1_a  <= a;
                s1_b  <= b;
            end
        end
    end

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op   (s1_op),
        .a    (s1_a),
        .b    (s1_b),
        .y    (core_y),
        .flags(core_flags)
    );

    // Result flops hold while stalled, so outputs stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            y        <= '0;
            s2_flags <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                y        <= core_y;
                s2_flags <= core_flags;
            end
        end
    end

    assign out_valid = s2_valid;
    assign zero      = s2_flags.zero;
    assign neg       = s2_flags.neg;
    assign carry     = s2_flags.carry;
    assign ovf       = s2_flags.ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized bench for alu_pipe against an arithmetic reference model and a result queue.
module tb_alu_pipe;

    localparam int unsigned W = 64;
    typedef logic [W+3:0] res_t;  // {y, zero, neg, carry, ovf}

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         zero;
    logic         neg;
    logic         carry;
    logic         ovf;

    int unsigned n_vec;
    int unsigned n_err;
    res_t        exp_q[$];
    logic        fixed_en;
    res_t        fixed_exp;

    alu_pipe #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .zero     (zero),
        .neg      (neg),
        .carry    (carry),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input res_t got, input res_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model: wide signed arithmetic for overflow, plain compares for carry.
    function automatic res_t model(input logic [2:0] mop, input logic [W-1:0] ma,
                                   input logic [W-1:0] mb);
        logic [W-1:0]        r;
        logic                c;
        logic                v;
        logic signed [W+1:0] sa;
        logic signed [W+1:0] sb;
        logic signed [W+1:0] ss;
        logic signed [W+1:0] max_s;
        logic signed [W+1:0] min_s;
        sa    = {{2{ma[W-1]}}, ma};
        sb    = {{2{mb[W-1]}}, mb};
        max_s = {3'b000, {(W-1){1'b1}}};
        min_s = {3'b111, {(W-1){1'b0}}};
        c     = 1'b0;
        v     = 1'b0;
        case (mop)
            3'd0: r = ma & mb;
            3'd1: r = ma | mb;
            3'd2: r = ma ^ mb;
            3'd3: r = ~ma;
            3'd4: begin
                r  = ma + mb;
                c  = r < ma;
                ss = sa + sb;
                v  = (ss > max_s) || (ss < min_s);
            end
            3'd5: begin
                r  = ma - mb;
                c  = ma >= mb;
                ss = sa - sb;
                v  = (ss > max_s) || (ss < min_s);
            end
            3'd6: r = ($signed(ma) < $signed(mb)) ? 64'd1 : 64'd0;
            default: r = ~(ma | mb);
        endcase
        return {r, (r == '0), r[W-1], c, v};
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called at a negedge: drive, sample transfers, score, advance to next negedge.
    task automatic run_cycle(input logic iv, input logic [2:0] iop, input logic [W-1:0] ia,
                             input logic [W-1:0] ib, input logic ordy,
                             output logic acc, output logic del);
        res_t e;
        in_valid  = iv;
        op        = iop;
        a         = ia;
        b         = ib;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        del = out_valid && out_ready;
        if (del) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", res_t'(out_valid), res_t'(0));
            end else begin
                e = exp_q.pop_front();
                check("result", {y, zero, neg, carry, ovf}, e);
            end
        end
        if (acc) exp_q.push_back(fixed_en ? fixed_exp : model(iop, ia, ib));
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy, output logic del);
        logic acc;
        run_cycle(1'b0, 3'd0, '0, '0, ordy, acc, del);
    endtask

    task automatic directed(input logic [2:0] dop, input logic [W-1:0] da,
                            input logic [W-1:0] db, input logic [W-1:0] ey,
                            input logic [3:0] ef);
        logic acc;
        logic del;
        fixed_en  = 1'b1;
        fixed_exp = {ey, ef};
        run_cycle(1'b1, dop, da, db, 1'b1, acc, del);
        fixed_en  = 1'b0;
        check("directed_accept", res_t'(acc), res_t'(1));
    endtask

    initial begin
        logic         acc;
        logic         del;
        logic [2:0]   bop[3];
        logic [W-1:0] ba[3];
        logic [W-1:0] bb[3];
        res_t         first;

        n_vec     = 0;
        n_err     = 0;
        fixed_en  = 1'b0;
        fixed_exp = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;

        #3;
        check("reset_outputs", {y, zero, neg, carry, ovf}, '0);
        check("reset_out_valid", res_t'(out_valid), res_t'(0));
        check("reset_in_ready", res_t'(in_ready), res_t'(1));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: single AND beat.
        directed(3'd0, 64'h405, 64'h403, 64'h401, 4'b0000);
        check("latency_edge1", res_t'(out_valid), res_t'(0));
        idle(1'b1, del);
        check("latency_edge2", res_t'(out_valid), res_t'(1));
        idle(1'b1, del);
        check("latency_deliver", res_t'(del), res_t'(1));

        // Directed corner table, streamed back-to-back.
        directed(3'd1, 64'h405, 64'h403, 64'h407, 4'b0000);
        directed(3'd2, 64'h405, 64'h403, 64'h006, 4'b0000);
        directed(3'd3, 64'h0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100);
        directed(3'd4, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b0101);
        directed(3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b1010);
        directed(3'd5, 64'h5, 64'h5, 64'h0, 4'b1010);
        directed(3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1, 4'b0000);
        directed(3'd6, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'b1000);
        directed(3'd7, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100);
        directed(3'd5, 64'h3, 64'h5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100);
        for (int i = 0; i < 3; i++) idle(1'b1, del);
        check("directed_drained", res_t'(exp_q.size()), res_t'(0));

        // Backpressure: three beats offered with out_ready low.
        for (int i = 0; i < 3; i++) begin
            bop[i] = 3'($urandom_range(0, 7));
            ba[i]  = rnd_operand();
            bb[i]  = rnd_operand();
        end
        first = model(bop[0], ba[0], bb[0]);
        run_cycle(1'b1, bop[0], ba[0], bb[0], 1'b0, acc, del);
        check("bp_accept0", res_t'(acc), res_t'(1));
        run_cycle(1'b1, bop[1], ba[1], bb[1], 1'b0, acc, del);
        check("bp_accept1", res_t'(acc), res_t'(1));
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, bop[2], ba[2], bb[2], 1'b0, acc, del);
            check("bp_in_ready_low", res_t'(acc), res_t'(0));
            check("bp_hold_y", {y, zero, neg, carry, ovf}, first);
            check("bp_out_valid", res_t'(out_valid), res_t'(1));
        end
        run_cycle(1'b1, bop[2], ba[2], bb[2], 1'b1, acc, del);
        check("bp_release_accept", res_t'(acc), res_t'(1));
        check("bp_drain0", res_t'(del), res_t'(1));
        idle(1'b1, del);
        check("bp_drain1", res_t'(del), res_t'(1));
        idle(1'b1, del);
        check("bp_drain2", res_t'(del), res_t'(1));
        idle(1'b1, del);
        check("bp_empty", res_t'(del), res_t'(0));

        // Streaming: 100 beats, no gaps after fill.
        for (int i = 0; i < 100; i++) begin
            run_cycle(1'b1, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 1'b1,
                      acc, del);
            check("stream_accept", res_t'(acc), res_t'(1));
            if (i >= 2) check("stream_gap", res_t'(del), res_t'(1));
        end
        idle(1'b1, del);
        check("stream_tail0", res_t'(del), res_t'(1));
        idle(1'b1, del);
        check("stream_tail1", res_t'(del), res_t'(1));
        check("stream_drained", res_t'(exp_q.size()), res_t'(0));

        // Random valid/ready traffic.
        for (int i = 0; i < 300; i++) begin
            run_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd_operand(),
                      rnd_operand(), 1'($urandom_range(0, 3) != 0), acc, del);
        end
        for (int i = 0; i < 3; i++) idle(1'b1, del);
        check("random_drained", res_t'(exp_q.size()), res_t'(0));

        // Reset with two beats in flight.
        run_cycle(1'b1, 3'd4, rnd_operand(), rnd_operand(), 1'b0, acc, del);
        run_cycle(1'b1, 3'd4, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, acc, del);
        check("pre_reset_valid", res_t'(out_valid), res_t'(1));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {y, zero, neg, carry, ovf}, '0);
        check("midrst_out_valid", res_t'(out_valid), res_t'(0));
        check("midrst_in_ready", res_t'(in_ready), res_t'(1));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", res_t'(in_ready), res_t'(1));
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, del);
            check("post_rst_no_stale", res_t'(del), res_t'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
